axi_req_arbiter: RTL

- Shares one AXI3 master port between the instruction-fetch sram-like port (read-only) and the data sram-like port (read/write).
- Sits between if_stage/exe_stage and the AXI bus in mycpu_top.
- Each source has at most one transaction in flight.
- Data reads win AR arbitration over instruction reads.

---
 rtl/axi_req_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/axi_req_arbiter.sv
// axi_req_arbiter
//   Shares one AXI3 master port between the instruction-fetch sram-like port
//   (read-only) and the data sram-like port (read/write). Each source has at
//   most one transaction in flight. Data reads win AR arbitration over
//   instruction reads. R beats are routed back by rid; B completes the
//   outstanding data write.
//
// Ports
//   aclk, aresetn                 clock (rising edge), async active-low reset
//   inst_req/inst_addr            fetch request (held until inst_addr_ok)
//   inst_addr_ok/inst_data_ok     fetch accepted / fetch data returned
//   inst_rdata                    fetch data, valid with inst_data_ok
//   data_req/wr/size/addr         data request (held until data_addr_ok)
//   data_wstrb/data_wdata         write strobes and data
//   data_addr_ok/data_data_ok     data accepted / read data or write response
//   data_rdata                    read data, valid with data_data_ok
//   ar*, r*, aw*, w*, b*          AXI3 master channels (ready outputs tied 1)
module axi_req_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_t;

  ar_state_t ar_state, ar_state_nxt;
  w_state_t  w_state, w_state_nxt;
  logic      inst_busy, data_busy;
  logic      awvalid_nxt, wvalid_nxt;
  logic      data_rd_acc, inst_rd_acc, data_wr_acc;
  logic      inst_rd_done, data_rd_done, data_wr_done;

  // Acceptance looks at the registered busy bits, so a source completing this
  // cycle cannot issue again until the next one.
  assign data_rd_acc = (ar_state == AR_IDLE) && data_req && !data_wr && !data_busy;
  assign inst_rd_acc = (ar_state == AR_IDLE) && !data_rd_acc && inst_req && !inst_busy;
  assign data_wr_acc = (w_state == W_IDLE) && data_req && data_wr && !data_busy;

  // Completions are gated by busy so stray beats after a reset are dropped.
  assign inst_rd_done = rvalid && (rid == INST_ID) && inst_busy;
  assign data_rd_done = rvalid && (rid == DATA_ID) && data_busy;
  assign data_wr_done = (w_state == W_RESP) && bvalid;

  assign inst_addr_ok = inst_rd_acc;
  assign data_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_data_ok = inst_rd_done;
  assign data_data_ok = data_rd_done || data_wr_done;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign rready       = 1'b1;
  assign bready       = 1'b1;
  assign arvalid      = (ar_state == AR_SEND);

  always_comb begin
    ar_state_nxt = ar_state;
    case (ar_state)
      AR_IDLE: if (data_rd_acc || inst_rd_acc) ar_state_nxt = AR_SEND;
      AR_SEND: if (arready) ar_state_nxt = AR_IDLE;
      default: ar_state_nxt = AR_IDLE;
    endcase
  end

  // AW and W complete independently; leave W_SEND once neither is pending.
  always_comb begin
    w_state_nxt = w_state;
    awvalid_nxt = awvalid;
    wvalid_nxt  = wvalid;
    case (w_state)
      W_IDLE: begin
        if (data_wr_acc) begin
          w_state_nxt = W_SEND;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
        end
      end
      W_SEND: begin
        if (awready) awvalid_nxt = 1'b0;
        if (wready)  wvalid_nxt  = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) w_state_nxt = W_RESP;
      end
      W_RESP: if (bvalid) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_state  <= AR_IDLE;
      w_state   <= W_IDLE;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      inst_busy <= 1'b0;
      data_busy <= 1'b0;
    end else begin
      ar_state <= ar_state_nxt;
      w_state  <= w_state_nxt;
      awvalid  <= awvalid_nxt;
      wvalid   <= wvalid_nxt;
      if (inst_rd_acc)       inst_busy <= 1'b1;
      else if (inst_rd_done) inst_busy <= 1'b0;
      if (data_rd_acc || data_wr_acc)        data_busy <= 1'b1;
      else if (data_rd_done || data_wr_done) data_busy <= 1'b0;
    end
  end

  // Payload registers: only meaningful while the matching valid is high.
  always_ff @(posedge aclk) begin
    if (data_rd_acc) begin
      arid   <= DATA_ID;
      araddr <= data_addr;
      arsize <= {1'b0, data_size};
    end else if (inst_rd_acc) begin
      arid   <= INST_ID;
      araddr <= inst_addr;
      arsize <= 3'd2;
    end
    if (data_wr_acc) begin
      awaddr <= data_addr;
      awsize <= {1'b0, data_size};
      wdata  <= data_wdata;
      wstrb  <= data_wstrb;
    end
  end

endmodule
